// File: rtl/prim_rr_onehot_arb.sv
// Round-robin arbiter with registered onehot grant, binary index and valid flag.
// Grants are held until accepted by a valid/ready handshake; err_o flags index/onehot disagreement.
module prim_rr_onehot_arb #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [AddrWidth-1:0] idx_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [NumReq-1:0]      gnt_q, gnt_d;
  logic [AddrWidth-1:0]   idx_q, idx_d;
  logic [AddrWidth-1:0]   ptr_q, ptr_d;

  logic [AddrWidth-1:0]   ptr_hs;
  logic [AddrWidth-1:0]   sel_base;
  logic [AddrWidth-1:0]   sel_idx;
  logic [NumReq-1:0]      sel_gnt;
  logic                   sel_found;
  logic                   handshake;
  int unsigned            cand;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign handshake = (state_q == GRANT) && ready_i;
  assign ptr_hs    = (idx_q == AddrWidth'(NumReq - 1)) ? '0 : idx_q + AddrWidth'(1);
  // On an accept the new selection must already use the advanced pointer.
  assign sel_base  = (state_q == GRANT) ? ptr_hs : ptr_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(sel_base) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = AddrWidth'(cand);
      end
    end
  end

  assign sel_gnt = NumReq'(1) << sel_idx;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = GRANT;
      GRANT:   if (ready_i && !sel_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    if (state_q == IDLE) begin
      gnt_d = sel_found ? sel_gnt : '0;
      idx_d = sel_found ? sel_idx : '0;
    end else if (handshake) begin
      ptr_d = ptr_hs;
      gnt_d = sel_found ? sel_gnt : '0;
      idx_d = sel_found ? sel_idx : '0;
    end else if (state_q != GRANT) begin
      gnt_d = '0;
      idx_d = '0;
    end
  end

  assign gnt_o   = gnt_q;
  assign idx_o   = idx_q;
  assign valid_o = (state_q == GRANT);
  assign err_o   = (gnt_q != (valid_o ? (NumReq'(1) << idx_q) : '0)) ||
                   ((state_q != IDLE) && (state_q != GRANT));

endmodule

// File: tb/tb_prim_rr_onehot_arb.sv
// Directed-vector bench for prim_rr_onehot_arb (NumReq=4 and NumReq=3) with queue-based checking.
module tb_prim_rr_onehot_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req4, gnt4;
  logic [1:0] idx4;
  logic       rdy4, vld4, err4;
  logic [2:0] req3, gnt3;
  logic [1:0] idx3;
  logic       rdy3, vld3, err3;

  prim_rr_onehot_arb #(.NumReq(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .gnt_o(gnt4), .idx_o(idx4),
    .valid_o(vld4), .ready_i(rdy4), .err_o(err4)
  );

  prim_rr_onehot_arb #(.NumReq(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .idx_o(idx3),
    .valid_o(vld3), .ready_i(rdy3), .err_o(err3)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] g;
    logic [1:0] i;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
    end
  endtask

  always @(posedge clk) cyc_no++;

  // Monitors: compare every presented output against the next queued expectation.
  always @(negedge clk) begin
    if (q4.size() != 0) begin
      e4 = q4.pop_front();
      cmp("n4_valid", 8'(vld4), 8'(e4.v));
      cmp("n4_gnt",   8'(gnt4), 8'(e4.g));
      cmp("n4_idx",   8'(idx4), 8'(e4.i));
      cmp("n4_err",   8'(err4), 8'(0));
    end
  end

  always @(negedge clk) begin
    if (q3.size() != 0) begin
      e3 = q3.pop_front();
      cmp("n3_valid", 8'(vld3), 8'(e3.v));
      cmp("n3_gnt",   8'(gnt3), 8'(e3.g[2:0]));
      cmp("n3_idx",   8'(idx3), 8'(e3.i));
      cmp("n3_err",   8'(err3), 8'(0));
    end
  end

  task automatic rst_cyc();
    rst = 1'b1; req4 = '0; rdy4 = 1'b0; req3 = '0; rdy3 = 1'b0;
    @(posedge clk);
    q4.push_back('0);
    q3.push_back('0);
    #1;
  endtask

  task automatic cyc4(input logic r, input logic [3:0] rq, input logic rd,
                      input logic v, input logic [3:0] g, input logic [1:0] i);
    rst = r; req4 = rq; rdy4 = rd;
    @(posedge clk);
    q4.push_back('{v: v, g: g, i: i});
    #1;
  endtask

  task automatic cyc3(input logic [2:0] rq, input logic rd,
                      input logic v, input logic [2:0] g, input logic [1:0] i);
    rst = 1'b0; req3 = rq; rdy3 = rd;
    @(posedge clk);
    q3.push_back('{v: v, g: {1'b0, g}, i: i});
    #1;
  endtask

  initial begin
    rst = 1'b1; req4 = '0; rdy4 = 1'b0; req3 = '0; rdy3 = 1'b0;
    rst_cyc();
    rst_cyc();

    // Request 1010 from ptr 0 selects idx 1 and holds while not ready.
    for (int k = 0; k < 6; k++) cyc4(1'b0, 4'b1010, 1'b0, 1'b1, 4'b0010, 2'd1);
    // Back-to-back accepts: idx 3, then wrap to ptr 0 and idx 1.
    cyc4(1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3);
    cyc4(1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1);
    // Move to idx 2, then drop requests: grant is sticky until accepted.
    cyc4(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);
    cyc4(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2);
    cyc4(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2);
    cyc4(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    // Pointer now 3: from IDLE, 1001 picks idx 3; accept wraps to idx 0.
    cyc4(1'b0, 4'b1001, 1'b0, 1'b1, 4'b1000, 2'd3);
    cyc4(1'b0, 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0);
    cyc4(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
    // Pointer now 1: 0100 grants idx 2; reset mid-grant drops it and clears ptr.
    cyc4(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2);
    cyc4(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2);
    cyc4(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0);
    cyc4(1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);
    cyc4(1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);

    // Corrupt the index register while a grant is held: err_o must rise at once.
    @(negedge clk);
    #1;
    force dut4.idx_q = 2'd1;
    #1;
    cmp("n4_err_fault", 8'(err4), 8'(1));
    release dut4.idx_q;
    rst_cyc();
    cyc4(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);

    // NumReq=3: continuous accepts rotate 0,1,2,0,1,2 wrapping at 3.
    cyc3(3'b111, 1'b1, 1'b1, 3'b001, 2'd0);
    cyc3(3'b111, 1'b1, 1'b1, 3'b010, 2'd1);
    cyc3(3'b111, 1'b1, 1'b1, 3'b100, 2'd2);
    cyc3(3'b111, 1'b1, 1'b1, 3'b001, 2'd0);
    cyc3(3'b111, 1'b1, 1'b1, 3'b010, 2'd1);
    cyc3(3'b111, 1'b1, 1'b1, 3'b100, 2'd2);
    cyc3(3'b000, 1'b1, 1'b0, 3'b000, 2'd0);
    // Ready without a grant is ignored; pointer wrapped to 0 so 110 picks idx 1.
    cyc3(3'b000, 1'b1, 1'b0, 3'b000, 2'd0);
    cyc3(3'b110, 1'b0, 1'b1, 3'b010, 2'd1);

    @(negedge clk);
    #1;
    cmp("q4_drained", 8'(q4.size()), 8'(0));
    cmp("q3_drained", 8'(q3.size()), 8'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
